cmult_acc: RTL and testbench
============================

CMULT_ACC -- requirements
Module: cmult_acc

Interface
REQ-001 Parameter Q, default 8, fractional bits of input and output samples.
REQ-002 Parameter N, default 16, sample width (signed two's complement, QN-Q.Q).
REQ-003 Parameter G, default 8, accumulator guard bits; the accumulator width is N+G.
REQ-004 Parameter CNT_W, default 9, width of the per-frame sample counter.
REQ-005 Port clk, input, 1, single clock; all state SHALL be updated on its rising edge.
REQ-006 Port rst_n, input, 1, reset; one clock, and reset is asynchronous and active-low.
REQ-007 Port in_valid, input, 1, qualifies in_pr/in_pi on this cycle.
REQ-008 Port in_last, input, 1, marks the final sample of a frame; ignored when in_valid=0.
REQ-009 Port in_pr, input, N, real product from the upstream complex multiplier.
REQ-010 Port in_pi, input, N, imaginary product from the upstream complex multiplier.
REQ-011 Port out_valid, output, 1, frame result is available.
REQ-012 Port out_ready, input, 1, the consumer accepts the result when out_valid&&out_ready.
REQ-013 Port out_sr, output, N, saturated real frame sum.
REQ-014 Port out_si, output, N, saturated imaginary frame sum.
REQ-015 Port out_cnt, output, CNT_W, number of samples in the frame.
REQ-016 Port out_sat, output, 1, either out_sr or out_si was clipped.
REQ-017 Port ovf, output, 1, sticky error: a frame result was lost, or the counter wrapped.

Function
REQ-018 The block SHALL never stall its input; the upstream multiplier has no backpressure and a 5-cycle fixed latency, so in_valid is the caller's 5-cycle-delayed copy of its own issue strobe.
REQ-019 Accumulation: on in_valid, acc_r += sext(in_pr) and acc_i += sext(in_pi) at N+G bits; there is no Q shift, since the inputs are already in Q format.
REQ-020 Counter: on in_valid, cnt += 1; if cnt is at all-ones, it SHALL wrap to 0 and set ovf.
REQ-021 On in_valid&&in_last, the final sums (including the current sample) and cnt+1 SHALL load the output register, out_valid SHALL assert on the next cycle, and the accumulators and counter SHALL clear to 0 in the same cycle.
REQ-022 Latency: from the in_last sample to out_valid is exactly 1 cycle.
REQ-023 Saturation: if a sum is above (2^(N-1))-1 or below -(2^(N-1)), the corresponding output SHALL clamp to that bound and out_sat=1.
REQ-024 FSM states: ACC (out register empty) and HOLD (out register full).
REQ-025 Transitions: ACC->HOLD on a last sample; HOLD->ACC on handshake with no new last; HOLD->HOLD on handshake with a simultaneous last (the new result loads and out_valid stays 1).
REQ-026 In HOLD, a last sample without out_ready SHALL drop the new result, keep the held result unchanged, set ovf, and still clear the accumulators.
REQ-027 out_sr, out_si, out_cnt and out_sat SHALL be stable while out_valid=1 && out_ready=0.
REQ-028 in_last on a frame of length 1 SHALL be legal: out_cnt=1 and the sums equal the single sample.
REQ-029 ovf SHALL clear only on reset.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force: out_valid=0, out_sr=0, out_si=0, out_cnt=0, out_sat=0, ovf=0, acc_r=0, acc_i=0, cnt=0, state=ACC.
REQ-031 Reset mid-frame SHALL discard the partial sums; the first valid sample after release starts a new frame.
REQ-032 Release SHALL be synchronized externally; no input sample is required in the first cycle after release.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (ACC=0, HOLD=1), the constant CMULT_LAT=5, and the saturation bound constants derived from N.
REQ-034 One sub-module, sat_clip (width N+G to N, outputs value and clip flag), SHALL be instantiated twice, once for the real part and once for the imaginary part.

Verification
REQ-035 Frame of 4 samples, each (1.0,-0.5) = (0x0100,0xFF80), with last on the 4th: the next cycle gives out_sr=0x0400, out_si=0xFE00, out_cnt=4, out_sat=0.
REQ-036 Frame of 200 samples of (0x7F00,0x8100): out_sr=0x7FFF, out_si=0x8000, out_sat=1, out_cnt=200.
REQ-037 Hold out_ready=0, then complete two frames: the first result is held unchanged, ovf=1, and the accumulators are cleared (a third 1-sample frame of 0x0010 reads 0x0010).
REQ-038 out_ready=1 on the same cycle as the next frame's last: the new result appears with no gap, out_valid stays 1, and ovf=0.
REQ-039 Assert rst_n=0 after 3 of 5 samples, then send a fresh 2-sample frame of (0x0100,0x0100): the result is (0x0200,0x0200) with out_cnt=2.
REQ-040 Send 512 samples with no last (CNT_W=9): the counter wraps and ovf=1.

Source files
------------

// File: rtl/cmult_acc_pkg.sv
// Shared definitions for the complex-product frame accumulator: FSM encoding,
// upstream multiplier latency and two's-complement saturation bounds.
package cmult_acc_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int CMULT_LAT = 5;
    localparam int SAMPLE_W  = 16;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    localparam longint SAT_MAX = sat_max(SAMPLE_W);
    localparam longint SAT_MIN = sat_min(SAMPLE_W);

endpackage

// File: rtl/cmult_acc_sat_clip.sv
// Narrows a signed accumulator value to OUT_W bits, clamping to the
// representable range and flagging when a clamp occurred.
module sat_clip
    import cmult_acc_pkg::*;
#(
    parameter int IN_W  = 24,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  i_val,
    output logic signed [OUT_W-1:0] o_val,
    output logic                    o_clip
);

    localparam logic signed [IN_W-1:0] HI = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] LO = IN_W'(sat_min(OUT_W));

    always_comb begin
        o_val  = i_val[OUT_W-1:0];
        o_clip = 1'b0;
        if (i_val > HI) begin
            o_val  = HI[OUT_W-1:0];
            o_clip = 1'b1;
        end else if (i_val < LO) begin
            o_val  = LO[OUT_W-1:0];
            o_clip = 1'b1;
        end
    end

endmodule

// File: rtl/cmult_acc.sv
// Accumulates complex products over a frame and presents the saturated frame
// sum through a one-entry output register; the input side never stalls.
module cmult_acc
    import cmult_acc_pkg::*;
#(
    parameter int Q     = 8,
    parameter int N     = 16,
    parameter int G     = 8,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [N-1:0]     in_pr,
    input  logic [N-1:0]     in_pi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sr,
    output logic [N-1:0]     out_si,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat,
    output logic             ovf
);

    localparam int ACC_W = N + G;
    localparam int INT_W = N - Q;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc_r;
    logic signed [ACC_W-1:0] r_acc_i;
    logic [CNT_W-1:0]        r_cnt;
    logic [N-1:0]            r_out_sr;
    logic [N-1:0]            r_out_si;
    logic [CNT_W-1:0]        r_out_cnt;
    logic                    r_out_sat;
    logic                    r_ovf;

    logic signed [ACC_W-1:0] w_sum_r;
    logic signed [ACC_W-1:0] w_sum_i;
    logic signed [N-1:0]     w_clip_r;
    logic signed [N-1:0]     w_clip_i;
    logic                    w_sat_r;
    logic                    w_sat_i;
    logic [CNT_W-1:0]        w_cnt_inc;
    logic                    w_last;
    logic                    w_wrap;
    logic                    w_load;
    logic                    w_drop;

    // Inputs are already in Q format, so they add straight in after sign extension.
    assign w_sum_r   = r_acc_r + ACC_W'(signed'(in_pr));
    assign w_sum_i   = r_acc_i + ACC_W'(signed'(in_pi));
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_last    = in_valid && in_last;
    assign w_wrap    = in_valid && (&r_cnt);
    assign w_load    = w_last && ((r_state == ST_ACC) || out_ready);
    assign w_drop    = w_last && (r_state == ST_HOLD) && !out_ready;

    // Output width expressed as integer plus fractional bits of the sample format.
    sat_clip #(.IN_W(ACC_W), .OUT_W(INT_W + Q)) u_clip_r (
        .i_val  (w_sum_r),
        .o_val  (w_clip_r),
        .o_clip (w_sat_r)
    );

    sat_clip #(.IN_W(ACC_W), .OUT_W(INT_W + Q)) u_clip_i (
        .i_val  (w_sum_i),
        .o_val  (w_clip_i),
        .o_clip (w_sat_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ACC;
            r_acc_r   <= '0;
            r_acc_i   <= '0;
            r_cnt     <= '0;
            r_out_sr  <= '0;
            r_out_si  <= '0;
            r_out_cnt <= '0;
            r_out_sat <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (in_valid) begin
                if (in_last) begin
                    r_acc_r <= '0;
                    r_acc_i <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc_r <= w_sum_r;
                    r_acc_i <= w_sum_i;
                    r_cnt   <= w_cnt_inc;
                end
            end
            if (w_load) begin
                r_out_sr  <= w_clip_r;
                r_out_si  <= w_clip_i;
                r_out_cnt <= w_cnt_inc;
                r_out_sat <= w_sat_r | w_sat_i;
            end
            // A result dropped while holding, or a counter wrap, is a sticky error.
            if (w_wrap || w_drop) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                ST_ACC:  if (w_last) r_state <= ST_HOLD;
                ST_HOLD: if (out_ready && !w_last) r_state <= ST_ACC;
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign out_valid = (r_state == ST_HOLD);
    assign out_sr    = r_out_sr;
    assign out_si    = r_out_si;
    assign out_cnt   = r_out_cnt;
    assign out_sat   = r_out_sat;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cmult_acc.sv
// Directed-vector bench for cmult_acc with hand-computed frame results.
module tb_cmult_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_pr = '0;
    logic [15:0] in_pi = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sr;
    logic [15:0] out_si;
    logic [8:0]  out_cnt;
    logic        out_sat;
    logic        ovf;

    int n_chk  = 0;
    int n_pass = 0;

    cmult_acc #(.Q(8), .N(16), .G(8), .CNT_W(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_pr     (in_pr),
        .in_pi     (in_pi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sr    (out_sr),
        .out_si    (out_si),
        .out_cnt   (out_cnt),
        .out_sat   (out_sat),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic send(input logic [15:0] pr, input logic [15:0] pi, input logic last);
        in_valid = 1'b1;
        in_pr    = pr;
        in_pi    = pi;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_sr",    32'(out_sr),    32'h0);
        chk("rst_cnt",   32'(out_cnt),   32'h0);
        chk("rst_ovf",   32'(ovf),       32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4 x (1.0, -0.5)
        for (int i = 0; i < 4; i++) begin
            send(16'h0100, 16'hFF80, i == 3);
            if (i == 2) chk("f4_not_yet_valid", 32'(out_valid), 32'h0);
        end
        chk("f4_valid", 32'(out_valid), 32'h1);
        chk("f4_sr",    32'(out_sr),    32'h0400);
        chk("f4_si",    32'(out_si),    32'hFE00);
        chk("f4_cnt",   32'(out_cnt),   32'd4);
        chk("f4_sat",   32'(out_sat),   32'h0);
        drain();
        chk("f4_drained", 32'(out_valid), 32'h0);

        // 200 samples driving both sums past the clamp
        for (int i = 0; i < 200; i++) send(16'h7F00, 16'h8100, i == 199);
        chk("sat_sr",  32'(out_sr),  32'h7FFF);
        chk("sat_si",  32'(out_si),  32'h8000);
        chk("sat_sat", 32'(out_sat), 32'h1);
        chk("sat_cnt", 32'(out_cnt), 32'd200);
        drain();

        // Held result survives a second frame completing without ready
        send(16'h0010, 16'h0020, 1'b0);
        send(16'h0010, 16'h0020, 1'b1);
        chk("hold_a_sr",  32'(out_sr),  32'h0020);
        chk("hold_a_si",  32'(out_si),  32'h0040);
        chk("hold_a_ovf", 32'(ovf),     32'h0);
        for (int i = 0; i < 3; i++) send(16'h0100, 16'h0100, i == 2);
        chk("hold_b_valid", 32'(out_valid), 32'h1);
        chk("hold_b_sr",    32'(out_sr),    32'h0020);
        chk("hold_b_si",    32'(out_si),    32'h0040);
        chk("hold_b_cnt",   32'(out_cnt),   32'd2);
        chk("hold_b_ovf",   32'(ovf),       32'h1);
        drain();
        send(16'h0010, 16'h0010, 1'b1);
        chk("hold_c_sr",  32'(out_sr),  32'h0010);
        chk("hold_c_si",  32'(out_si),  32'h0010);
        chk("hold_c_cnt", 32'(out_cnt), 32'd1);
        chk("hold_c_ovf", 32'(ovf),     32'h1);

        // Asynchronous reset from a full output register
        rst_n = 1'b0;
        #2;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_sr",    32'(out_sr),    32'h0);
        chk("arst_cnt",   32'(out_cnt),   32'h0);
        chk("arst_ovf",   32'(ovf),       32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Handshake coinciding with the next frame's last
        send(16'h0100, 16'h0000, 1'b1);
        chk("b2b_first_sr", 32'(out_sr), 32'h0100);
        send(16'h0030, 16'h0000, 1'b0);
        out_ready = 1'b1;
        send(16'h0030, 16'h0001, 1'b1);
        out_ready = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'h1);
        chk("b2b_sr",    32'(out_sr),    32'h0060);
        chk("b2b_si",    32'(out_si),    32'h0001);
        chk("b2b_cnt",   32'(out_cnt),   32'd2);
        chk("b2b_ovf",   32'(ovf),       32'h0);
        drain();

        // Reset mid-frame discards the partial sums
        for (int i = 0; i < 3; i++) send(16'h0100, 16'h0100, 1'b0);
        pulse_reset();
        send(16'h0100, 16'h0100, 1'b0);
        send(16'h0100, 16'h0100, 1'b1);
        chk("mid_sr",  32'(out_sr),  32'h0200);
        chk("mid_si",  32'(out_si),  32'h0200);
        chk("mid_cnt", 32'(out_cnt), 32'd2);
        drain();

        // Counter wrap at 512 samples without a last
        for (int i = 0; i < 511; i++) send(16'h0000, 16'h0000, 1'b0);
        chk("wrap_before_ovf", 32'(ovf), 32'h0);
        send(16'h0000, 16'h0000, 1'b0);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        send(16'h0005, 16'h0003, 1'b1);
        chk("wrap_cnt", 32'(out_cnt), 32'd1);
        chk("wrap_sr",  32'(out_sr),  32'h0005);
        chk("wrap_si",  32'(out_si),  32'h0003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
